// File: rtl/bh_rollback_ctrl_pkg.sv
// Shared types for the gshare branch-history checkpoint queue.
// The history width here must track the predictor's GHT width.
package bh_rollback_ctrl_pkg;

  localparam int BH_GHT_BIT = 4;

  typedef enum logic {
    IDLE     = 1'b0,
    ROLLBACK = 1'b1
  } rb_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  resolved;
    logic [BH_GHT_BIT-1:0] gh;
    logic                  taken;
  } bh_entry_t;

endpackage

// File: rtl/bh_rollback_ctrl_if.sv
// Prediction-allocate and branch-resolve handshakes between fetch/execute
// (master) and the checkpoint queue (slave).
interface bh_rollback_ctrl_if #(
  parameter int GHT_BIT = bh_rollback_ctrl_pkg::BH_GHT_BIT,
  parameter int TAG_W   = 3
);
  logic               pred_valid;
  logic [GHT_BIT-1:0] pred_gh;
  logic               pred_taken;
  logic               pred_ready;
  logic [TAG_W-1:0]   pred_tag;

  logic               resolve_valid;
  logic [TAG_W-1:0]   resolve_tag;
  logic               resolve_taken;
  logic               resolve_ready;

  modport master (
    output pred_valid, pred_gh, pred_taken,
    output resolve_valid, resolve_tag, resolve_taken,
    input  pred_ready, pred_tag, resolve_ready
  );

  modport slave (
    input  pred_valid, pred_gh, pred_taken,
    input  resolve_valid, resolve_tag, resolve_taken,
    output pred_ready, pred_tag, resolve_ready
  );
endinterface

// File: rtl/bh_rollback_ctrl.sv
// In-order checkpoint queue for in-flight branches; on a mispredict it squashes
// younger entries and pulses the predictor's history-restore/PHT-flip for one cycle.
module bh_rollback_ctrl
  import bh_rollback_ctrl_pkg::*;
#(
  parameter int GHT_BIT = BH_GHT_BIT,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  bh_rollback_ctrl_if.slave    bus,
  output logic                 bp_clear_en,
  output logic                 bp_bh_pred_valid,
  output logic [GHT_BIT-1:0]   bp_gh_out,
  output logic [TAG_W:0]       count,
  output logic                 empty
);

  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);

  rb_state_e                   state, state_nxt;
  bh_entry_t [DEPTH-1:0]       q;
  logic [TAG_W-1:0]            head, tail;
  logic [TAG_W:0]              count_nxt;
  logic [DEPTH-1:0]            squash;

  bh_entry_t                   rs_ent;
  logic [TAG_W-1:0]            rs_off;
  logic                        rs_fire, mispredict, retire, enq;

  assign rs_ent     = q[bus.resolve_tag];
  assign rs_off     = bus.resolve_tag - head;
  // Resolutions against squashed or retired slots are stale and ignored.
  assign rs_fire    = bus.resolve_valid & bus.resolve_ready & rs_ent.valid;
  assign mispredict = rs_fire & (bus.resolve_taken != rs_ent.taken);
  assign retire     = q[head].valid & q[head].resolved;

  assign bus.resolve_ready = (state == IDLE);
  assign bus.pred_ready    = (state == IDLE) & (count != CNT_FULL) & ~mispredict;
  assign bus.pred_tag      = tail;
  assign enq               = bus.pred_valid & bus.pred_ready;

  assign bp_clear_en      = (state == ROLLBACK);
  assign bp_bh_pred_valid = (state == ROLLBACK);
  assign empty            = (count == '0);

  // Younger than the mispredicted branch = further from head in ring order.
  always_comb begin
    squash = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash[i] = (TAG_W'(i) - head) > rs_off;
    end
  end

  always_comb begin
    count_nxt = count;
    if (mispredict)  count_nxt = (TAG_W+1)'(rs_off) + CNT_ONE;
    else if (enq)    count_nxt = count + CNT_ONE;
    if (retire)      count_nxt = count_nxt - CNT_ONE;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (mispredict) state_nxt = ROLLBACK;
      ROLLBACK: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q         <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      bp_gh_out <= '0;
    end else begin
      if (enq) begin
        q[tail] <= '{valid: 1'b1, resolved: 1'b0, gh: bus.pred_gh, taken: bus.pred_taken};
      end
      if (rs_fire) begin
        q[bus.resolve_tag].resolved <= 1'b1;
        q[bus.resolve_tag].taken    <= bus.resolve_taken;
      end
      if (mispredict) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (squash[i]) q[i].valid <= 1'b0;
        end
        tail      <= bus.resolve_tag + TAG_ONE;
        bp_gh_out <= rs_ent.gh;
      end else if (enq) begin
        tail <= tail + TAG_ONE;
      end
      // Placed last so a retiring head always ends up invalid.
      if (retire) begin
        q[head].valid <= 1'b0;
        head          <= head + TAG_ONE;
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_bh_rollback_ctrl.sv
// Directed bench for bh_rollback_ctrl: allocation, in-order retire, wrap,
// mispredict squash/rollback pulse and reset during rollback.
module tb_bh_rollback_ctrl;

  localparam int GHT_BIT = 4;
  localparam int DEPTH   = 8;
  localparam int TAG_W   = 3;

  logic               clock;
  logic               reset;
  logic               bp_clear_en;
  logic               bp_bh_pred_valid;
  logic [GHT_BIT-1:0] bp_gh_out;
  logic [TAG_W:0]     count;
  logic               empty;

  int n_chk  = 0;
  int n_fail = 0;

  bh_rollback_ctrl_if #(.GHT_BIT(GHT_BIT), .TAG_W(TAG_W)) bus ();

  bh_rollback_ctrl #(.GHT_BIT(GHT_BIT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus),
    .bp_clear_en      (bp_clear_en),
    .bp_bh_pred_valid (bp_bh_pred_valid),
    .bp_gh_out        (bp_gh_out),
    .count            (count),
    .empty            (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset             = 1'b1;
    bus.pred_valid    = 1'b0;
    bus.pred_gh       = '0;
    bus.pred_taken    = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_tag   = '0;
    bus.resolve_taken = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic enq(input logic [3:0] gh, input logic taken, input int exp_tag);
    bus.pred_valid = 1'b1;
    bus.pred_gh    = gh;
    bus.pred_taken = taken;
    #1;
    chk("enq_ready", bus.pred_ready, 1);
    chk("enq_tag", bus.pred_tag, exp_tag);
    tick();
    bus.pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic [2:0] tag, input logic taken);
    bus.resolve_valid = 1'b1;
    bus.resolve_tag   = tag;
    bus.resolve_taken = taken;
    tick();
    bus.resolve_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_pred_ready", bus.pred_ready, 1);
    chk("rst_resolve_ready", bus.resolve_ready, 1);
    chk("rst_pred_tag", bus.pred_tag, 0);
    chk("rst_clear_en", bp_clear_en, 0);
    chk("rst_bh_valid", bp_bh_pred_valid, 0);
    chk("rst_gh_out", bp_gh_out, 0);

    // Three enqueues, out-of-order resolution, in-order retire
    enq(4'h1, 1'b0, 0);
    enq(4'h2, 1'b0, 1);
    enq(4'h3, 1'b0, 2);
    chk("t1_count3", count, 3);
    chk("t1_not_empty", empty, 0);
    resolve(3'd2, 1'b0);
    chk("t1_no_retire_tag2", count, 3);
    resolve(3'd0, 1'b0);
    chk("t1_retire_next_edge", count, 3);
    resolve(3'd1, 1'b0);
    chk("t1_retire0", count, 2);
    tick();
    chk("t1_retire1", count, 1);
    tick();
    chk("t1_retire2", count, 0);
    chk("t1_empty", empty, 1);

    // Fill to DEPTH, then free the head and see the tag wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) enq(4'(i), i[0], i);
    chk("t2_full_count", count, 8);
    chk("t2_full_ready", bus.pred_ready, 0);
    resolve(3'd0, 1'b0);
    chk("t2_full_still", bus.pred_ready, 0);
    tick();
    chk("t2_count7", count, 7);
    chk("t2_ready_again", bus.pred_ready, 1);
    chk("t2_wrap_tag", bus.pred_tag, 0);

    // Mispredict on tag 1 with a wrong-path prediction in the same cycle
    do_reset();
    enq(4'h5, 1'b1, 0);
    enq(4'hA, 1'b1, 1);
    enq(4'h6, 1'b1, 2);
    enq(4'h7, 1'b1, 3);
    enq(4'h8, 1'b1, 4);
    bus.resolve_valid = 1'b1;
    bus.resolve_tag   = 3'd1;
    bus.resolve_taken = 1'b0;
    bus.pred_valid    = 1'b1;
    bus.pred_gh       = 4'hF;
    bus.pred_taken    = 1'b0;
    #1;
    chk("t3_ready_mp", bus.pred_ready, 0);
    tick();
    bus.resolve_valid = 1'b0;
    bus.pred_valid    = 1'b0;
    chk("t3_count", count, 2);
    chk("t3_tail", bus.pred_tag, 2);
    chk("t3_clear_en", bp_clear_en, 1);
    chk("t3_bh_valid", bp_bh_pred_valid, 1);
    chk("t3_gh_out", bp_gh_out, 4'hA);
    chk("t3_rb_pred_ready", bus.pred_ready, 0);
    chk("t3_rb_resolve_ready", bus.resolve_ready, 0);
    tick();
    chk("t3_clear_en_off", bp_clear_en, 0);
    chk("t3_bh_valid_off", bp_bh_pred_valid, 0);
    chk("t3_gh_hold", bp_gh_out, 4'hA);
    chk("t3_idle_pred_ready", bus.pred_ready, 1);
    chk("t3_idle_resolve_ready", bus.resolve_ready, 1);
    chk("t3_idle_tag", bus.pred_tag, 2);
    resolve(3'd3, 1'b0);
    chk("t3_stale_count", count, 2);
    chk("t3_stale_no_rb", bp_clear_en, 0);

    // Mispredict on head with head at 7 and tail at 2
    do_reset();
    for (int i = 0; i < 7; i++) enq(4'(i), 1'b0, i);
    for (int i = 0; i < 7; i++) resolve(3'(i), 1'b0);
    tick();
    chk("t5_drained", count, 0);
    chk("t5_tail7", bus.pred_tag, 7);
    enq(4'h3, 1'b0, 7);
    enq(4'h4, 1'b0, 0);
    enq(4'h5, 1'b0, 1);
    chk("t5_count3", count, 3);
    resolve(3'd7, 1'b1);
    chk("t5_count1", count, 1);
    chk("t5_tail0", bus.pred_tag, 0);
    chk("t5_gh_out", bp_gh_out, 4'h3);
    chk("t5_clear_en", bp_clear_en, 1);
    tick();
    chk("t5_retire_in_rb", count, 0);
    chk("t5_clear_off", bp_clear_en, 0);
    chk("t5_tail_hold", bus.pred_tag, 0);

    // Reset while the rollback pulse is up
    do_reset();
    enq(4'h9, 1'b0, 0);
    enq(4'h2, 1'b0, 1);
    resolve(3'd0, 1'b1);
    chk("t6_in_rb", bp_clear_en, 1);
    reset = 1'b1;
    tick();
    chk("t6_clear_en", bp_clear_en, 0);
    chk("t6_bh_valid", bp_bh_pred_valid, 0);
    chk("t6_gh_out", bp_gh_out, 0);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_idle", bus.resolve_ready, 1);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bh_rollback_ctrl.md
# bh_rollback_ctrl

Checkpoint queue and rollback sequencer for the gshare predictor. Records the global-history snapshot and predicted direction of every in-flight branch, tracks out-of-order resolution, and retires entries in order. On a mispredict it squashes younger entries and drives the predictor's rollback inputs (history restore plus PHT flip) for exactly one cycle, blocking new predictions meanwhile. Sits between the gshare predictor/fetch and the branch-resolution path in execute.

## Interface
- GHT_BIT, 4, global history width; must match the predictor
- DEPTH, 8, queue entries; power of two, ≥2
- TAG_W, $clog2(DEPTH), tag width (derived)

- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- pred_valid  in  1  predictor produced a prediction this cycle; legal only when pred_ready=1
- pred_gh  in  GHT_BIT  history used to index the PHT for this branch
- pred_taken  in  1  predicted direction
- pred_ready  out  1  entry can be allocated (state IDLE, count<DEPTH, no mispredict this cycle)
- pred_tag  out  TAG_W  tag assigned to an entry enqueued this cycle (= tail)
- resolve_valid  in  1  branch resolved
- resolve_tag  in  TAG_W  tag of resolved branch
- resolve_taken  in  1  actual direction
- resolve_ready  out  1  high in IDLE only; resolutions must be held while low
- bp_clear_en  out  1  to predictor clear_en
- bp_bh_pred_valid  out  1  to predictor obq_bh_pred_valid
- bp_gh_out  out  GHT_BIT  to predictor obq_gh_in
- count  out  TAG_W+1  occupied entries
- empty  out  1  count==0

## Operation
- Entry fields: valid, resolved, gh, taken. Circular buffer with head, tail (TAG_W bits, wrap mod DEPTH) and count.
- Enqueue (pred_valid & pred_ready): write {1,0,pred_gh,pred_taken} at tail; tail+1; count+1.
- Resolve (resolve_valid & resolve_ready), entry at resolve_tag:
  - entry invalid (squashed/retired): ignored, no state change.
  - resolve_taken==taken: set resolved.
  - resolve_taken!=taken (mispredict): set resolved, taken←resolve_taken; tail←tag+1; count←((tag−head) mod DEPTH)+1; clear valid on all younger entries; latch gh into rollback register; go ROLLBACK.
- Retire: if head entry valid & resolved, clear it, head+1, count−1; one per cycle.
- Simultaneous enqueue + mispredict: pred_ready is low that cycle; any pred_valid is dropped (wrong path).
- Simultaneous enqueue + retire: both apply; count net unchanged.
- Retire and mispredict same cycle: both apply; count accounts for both.
- FSM: IDLE → ROLLBACK on mispredict; ROLLBACK → IDLE unconditionally after one cycle. In ROLLBACK: bp_clear_en=1, bp_bh_pred_valid=1, bp_gh_out=latched gh; pred_ready=0, resolve_ready=0; retirement continues.
- In IDLE: bp_clear_en=0, bp_bh_pred_valid=0, bp_gh_out holds last value.
- Full (count==DEPTH): pred_ready=0; resolution/retire still proceed.

## Timing
- Reset: all entries invalid, head=tail=0, count=0, empty=1, state IDLE, pred_ready=1, resolve_ready=1, pred_tag=0, bp_clear_en=0, bp_bh_pred_valid=0, bp_gh_out=0. Reset mid-rollback aborts it; outputs zero next cycle.
- Enqueue visible in count/empty one cycle after the accepting edge.
- Mispredict accepted at edge N → rollback outputs high for exactly cycle N+1 → IDLE, pred_ready high (if not full) in N+2.
- Retire: entry resolved at edge N retires at edge N+1 at the earliest.
- All outputs registered except pred_ready, pred_tag, resolve_ready (decoded from state/count/tail and current mispredict).

## Structure
- Shared package: entry struct {valid, resolved, gh, taken}, state enum {IDLE, ROLLBACK}, GHT_BIT default matching the predictor.
- Single module; no sub-module.

## Test plan
- Reset then 3 enqueues (gh 0x1,0x2,0x3) → tags 0,1,2, count=3; resolve all correct in order 2,0,1 → retire at tags 0,1,2 only after tag 0 and 1 resolved, count reaches 0.
- Fill 8 entries → pred_ready=0 at count=8; resolve+retire head → pred_ready=1, next tag 0 (wrap).
- Entries tags 0–4, mispredict on tag 1 (gh=0xA) → count=2, tail=2, next cycle bp_clear_en=bp_bh_pred_valid=1, bp_gh_out=0xA for one cycle; resolve of tag 3 afterwards ignored.
- pred_valid asserted in mispredict cycle → entry not written, tail=tag+1, count unchanged by it.
- Mispredict on head with head wrapped at 7, tail at 2 → count=1, tail=0.
- Reset asserted during ROLLBACK → next cycle all rollback outputs 0, count=0, state IDLE.
